// File: rtl/draw_card_if.sv
// VGA pixel stream bundle shared by the timing generator, background and
// sprite stages. One sample per pixel clock, no handshake.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
endinterface

// File: rtl/draw_card.sv
// draw_card: two-stage sprite overlay. Stage 1 decides whether the pixel
// falls inside the card and issues the ROM address; stage 2 picks the
// final colour using the ROM word that returns one cycle later. Card
// position and identity are latched at pixel (0,0) so a card never tears.
//
// Stream semantics: there is no valid/ready handshake. Every clock carries
// one pixel, the stage never stalls and applies no back-pressure; every
// field leaves exactly two clocks after it entered.
module draw_card #(
  parameter int          CARD_W      = 48,
  parameter int          CARD_H      = 64,
  parameter int          N_CARDS     = 52,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic [5:0]  card_id,
  output logic [17:0] rom_addr,
  input  logic [11:0] rom_data
);

  // Frame latch
  logic [10:0] x_l_q, x_l_d;
  logic [10:0] y_l_q, y_l_d;
  logic [5:0]  id_l_q, id_l_d;

  // Stage 1
  logic [10:0] s1_hcount_q, s1_vcount_q;
  logic        s1_hblnk_q, s1_vblnk_q, s1_hsync_q, s1_vsync_q;
  logic [11:0] s1_rgb_q;
  logic        s1_in_card_q, in_card_d;
  logic [17:0] rom_addr_q, rom_addr_d;

  // Stage 2
  logic [10:0] s2_hcount_q, s2_vcount_q;
  logic        s2_hblnk_q, s2_vblnk_q, s2_hsync_q, s2_vsync_q;
  logic [11:0] s2_rgb_q, s2_rgb_d;

  logic        frame_start;
  logic [11:0] x_end, y_end;
  logic [10:0] dx, dy;
  logic [17:0] card_addr;

  // Next-value latch mux and stage-1 hit test / address. Stage 1 reads the
  // mux output so pixel (0,0) already sees the values latched on that edge.
  always_comb begin
    frame_start = (vga_in.hcount == 11'd0) && (vga_in.vcount == 11'd0);
    x_l_d  = frame_start ? xpos    : x_l_q;
    y_l_d  = frame_start ? ypos    : y_l_q;
    id_l_d = frame_start ? card_id : id_l_q;

    // 12-bit right/bottom edges so a card near 2047 does not wrap to x=0
    x_end = {1'b0, x_l_d} + 12'(CARD_W);
    y_end = {1'b0, y_l_d} + 12'(CARD_H);

    in_card_d = ({1'b0, vga_in.hcount} >= {1'b0, x_l_d}) &&
                ({1'b0, vga_in.hcount} <  x_end) &&
                ({1'b0, vga_in.vcount} >= {1'b0, y_l_d}) &&
                ({1'b0, vga_in.vcount} <  y_end) &&
                (32'(id_l_d) < 32'(N_CARDS));

    dx = vga_in.hcount - x_l_d;
    dy = vga_in.vcount - y_l_d;
    card_addr = 18'(id_l_d) * 18'(CARD_W * CARD_H)
              + 18'(dy) * 18'(CARD_W)
              + 18'(dx);

    // Outside the card the address is don't-care; holding it avoids
    // needless ROM address toggling.
    rom_addr_d = in_card_d ? card_addr : rom_addr_q;
  end

  // Stage-2 colour select: blanking forces black, then opaque card pixels,
  // otherwise the upstream colour passes through.
  always_comb begin
    s2_rgb_d = s1_rgb_q;
    if (s1_hblnk_q || s1_vblnk_q) begin
      s2_rgb_d = 12'h000;
    end else if (s1_in_card_q && (rom_data != TRANSPARENT)) begin
      s2_rgb_d = rom_data;
    end
  end

  // Frame latch and both pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_l_q        <= '0;
      y_l_q        <= '0;
      id_l_q       <= 6'h3F;
      s1_hcount_q  <= '0;
      s1_vcount_q  <= '0;
      s1_hblnk_q   <= 1'b0;
      s1_vblnk_q   <= 1'b0;
      s1_hsync_q   <= 1'b0;
      s1_vsync_q   <= 1'b0;
      s1_rgb_q     <= '0;
      s1_in_card_q <= 1'b0;
      rom_addr_q   <= '0;
      s2_hcount_q  <= '0;
      s2_vcount_q  <= '0;
      s2_hblnk_q   <= 1'b0;
      s2_vblnk_q   <= 1'b0;
      s2_hsync_q   <= 1'b0;
      s2_vsync_q   <= 1'b0;
      s2_rgb_q     <= '0;
    end else begin
      x_l_q        <= x_l_d;
      y_l_q        <= y_l_d;
      id_l_q       <= id_l_d;
      s1_hcount_q  <= vga_in.hcount;
      s1_vcount_q  <= vga_in.vcount;
      s1_hblnk_q   <= vga_in.hblnk;
      s1_vblnk_q   <= vga_in.vblnk;
      s1_hsync_q   <= vga_in.hsync;
      s1_vsync_q   <= vga_in.vsync;
      s1_rgb_q     <= vga_in.rgb;
      s1_in_card_q <= in_card_d;
      rom_addr_q   <= rom_addr_d;
      s2_hcount_q  <= s1_hcount_q;
      s2_vcount_q  <= s1_vcount_q;
      s2_hblnk_q   <= s1_hblnk_q;
      s2_vblnk_q   <= s1_vblnk_q;
      s2_hsync_q   <= s1_hsync_q;
      s2_vsync_q   <= s1_vsync_q;
      s2_rgb_q     <= s2_rgb_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign vga_out.hcount = s2_hcount_q;
  assign vga_out.vcount = s2_vcount_q;
  assign vga_out.hblnk  = s2_hblnk_q;
  assign vga_out.vblnk  = s2_vblnk_q;
  assign vga_out.hsync  = s2_hsync_q;
  assign vga_out.vsync  = s2_vsync_q;
  assign vga_out.rgb    = s2_rgb_q;

endmodule

// File: tb/tb_draw_card.sv
// Bench for draw_card: drives an 800x600-style pixel stream (windows of it),
// models the ROM as a function of rom_addr, and keeps an expected-output
// queue that is popped two clocks after each pixel is driven.
module tb_draw_card;
  localparam int W = 38;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] xpos = '0;
  logic [10:0] ypos = '0;
  logic [5:0]  card_id = 6'h3F;
  logic [17:0] rom_addr;
  logic [11:0] rom_data;
  int          rom_mode = 0;

  vga_if vin();
  vga_if vout();

  draw_card dut (
    .clk      (clk),
    .rst      (rst),
    .vga_in   (vin),
    .vga_out  (vout),
    .xpos     (xpos),
    .ypos     (ypos),
    .card_id  (card_id),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ROM model: mode 0 returns address low 12 bits, mode 1 marks even
  // addresses transparent.
  function automatic logic [11:0] rom_fn(input logic [17:0] a, input int mode);
    if (mode == 1 && a[0] == 1'b0) return 12'hF0F;
    return a[11:0];
  endfunction

  always_comb rom_data = rom_fn(rom_addr, rom_mode);

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mx = 0, my = 0, mid = 63;

  function automatic logic [W-1:0] out_bundle();
    return {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk,
            vout.hsync, vout.vsync, vout.rgb};
  endfunction

  // driver: one pixel per clock, model update, and checks after the edge
  task automatic step(input int h, input int v, input logic hb, input logic vb,
                      input logic hs, input logic vs, input logic [11:0] bg);
    logic [W-1:0] e;
    logic [W-1:0] got;
    logic [W-1:0] want;
    logic [11:0]  rd;
    logic [11:0]  col;
    logic         ic;
    int           a;
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = bg;
    if (rst) begin
      mx = 0; my = 0; mid = 63;
    end else if (h == 0 && v == 0) begin
      mx = int'(xpos); my = int'(ypos); mid = int'(card_id);
    end
    ic = !rst && (h >= mx) && (h < mx + 48) && (v >= my) && (v < my + 64) && (mid < 52);
    a  = (mid * 3072 + (v - my) * 48 + (h - mx)) & 32'h3FFFF;
    rd = rom_fn(18'(a), rom_mode);
    if (hb || vb)                  col = 12'h000;
    else if (ic && rd != 12'hF0F)  col = rd;
    else                           col = bg;
    e = {11'(h), 11'(v), hb, vb, hs, vs, col};
    if (rst) begin
      e = '0;
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      n_checks++;
      if (rom_addr !== 18'd0) begin
        n_fail++;
        $display("FAIL rom_addr_reset: got %0d expected 0", rom_addr);
      end
    end else if (ic) begin
      n_checks++;
      if (rom_addr !== 18'(a)) begin
        n_fail++;
        $display("FAIL rom_addr at (%0d,%0d): got %0d expected %0d", h, v, rom_addr, a);
      end
    end
    if (exp_q.size() == 2) begin
      want = exp_q.pop_front();
      got  = out_bundle();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL vga_out: got h=%0d v=%0d blk/sync=%b rgb=%h expected h=%0d v=%0d blk/sync=%b rgb=%h",
                 got[37:27], got[26:16], got[15:12], got[11:0],
                 want[37:27], want[26:16], want[15:12], want[11:0]);
      end
    end
  endtask

  task automatic pix(input int h, input int v, input logic [11:0] bg);
    step(h, v, h >= 800, v >= 600, (h >= 840) && (h < 968), (v >= 601) && (v < 605), bg);
  endtask

  // bg < 0 selects a random background per pixel
  task automatic scan(input int v0, input int v1, input int h0, input int h1, input int bg);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        pix(h, v, (bg < 0) ? 12'($urandom_range(0, 4095)) : 12'(bg));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    card_id = 6'h3F;
    for (int i = 0; i < 3; i++) pix(400 + i, 10, 12'($urandom_range(0, 4095)));
    n_checks++;
    if (out_bundle() !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected 0", out_bundle());
    end
    rst = 1'b0;
    scan(10, 10, 403, 420, -1);
  endtask

  task automatic test_reset_midframe();
    rom_mode = 0;
    xpos = 11'd50; ypos = 11'd20; card_id = 6'd3;
    pix(0, 0, 12'h0AA);
    scan(30, 30, 45, 70, -1);
    rst = 1'b1;
    pix(71, 30, 12'h111);
    pix(72, 30, 12'h222);
    rst = 1'b0;
    // card must stay hidden until the next frame start
    scan(31, 32, 45, 100, -1);
    pix(0, 0, 12'h0AA);
    scan(33, 33, 45, 100, -1);
  endtask

  task automatic test_passthrough();
    card_id = 6'h3F;
    pix(0, 0, 12'h123);
    scan(0, 2, 1, 1055, 12'h123);
    scan(598, 603, 790, 980, 12'h123);
  endtask

  task automatic test_placement();
    rom_mode = 0;
    xpos = 11'd100; ypos = 11'd200; card_id = 6'd1;
    pix(0, 0, 12'h456);
    pix(100, 200, 12'h456);
    n_checks++;
    if (rom_addr !== 18'd3072) begin
      n_fail++;
      $display("FAIL rom_addr_topleft: got %0d expected 3072", rom_addr);
    end
    pix(147, 263, 12'h456);
    n_checks++;
    if (rom_addr !== 18'd6143) begin
      n_fail++;
      $display("FAIL rom_addr_botright: got %0d expected 6143", rom_addr);
    end
    scan(199, 201, 95, 152, -1);
    scan(262, 264, 95, 152, -1);
  endtask

  task automatic test_transparency();
    rom_mode = 1;
    scan(200, 202, 97, 150, -1);
    rom_mode = 0;
    pix(1, 1, 12'h000);
    pix(2, 1, 12'h000);
  endtask

  task automatic test_frame_latch();
    rom_mode = 0;
    xpos = 11'd100; ypos = 11'd200; card_id = 6'd1;
    pix(0, 0, 12'h321);
    scan(248, 249, 95, 150, -1);
    xpos = 11'd300;
    scan(250, 252, 95, 352, -1);
    pix(0, 0, 12'h321);
    scan(250, 251, 95, 352, -1);
  endtask

  task automatic test_edge_clip();
    rom_mode = 0;
    xpos = 11'd780; ypos = 11'd580; card_id = 6'd5;
    pix(0, 0, 12'h777);
    scan(578, 606, 0, 60, -1);
    scan(578, 606, 770, 835, -1);
    // card straddling 2047: visible columns must not reappear near x=0
    xpos = 11'd2040; ypos = 11'd10; card_id = 6'd0;
    pix(0, 0, 12'h777);
    for (int v = 10; v <= 11; v++) begin
      for (int h = 2035; h <= 2047; h++) step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)));
      for (int h = 0; h <= 50; h++)      step(h, v, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)));
    end
  endtask

  task automatic test_simultaneous();
    card_id = 6'h3F; xpos = 11'd0; ypos = 11'd0;
    pix(0, 0, 12'h0F0);
    pix(1, 0, 12'h0F0);
    card_id = 6'd2;
    scan(0, 1, 0, 50, -1);
  endtask

  task automatic test_back_to_back();
    int h;
    int v;
    for (int f = 0; f < 3; f++) begin
      xpos    = 11'($urandom_range(0, 900));
      ypos    = 11'($urandom_range(0, 650));
      card_id = 6'($urandom_range(40, 63));
      rom_mode = f % 2;
      pix(0, 0, 12'h5A5);
      for (int i = 0; i < 300; i++) begin
        h = int'(xpos) + $urandom_range(0, 60) - 5;
        v = int'(ypos) + $urandom_range(0, 75) - 5;
        if (h < 0) h = 1;
        if (v < 0) v = 1;
        if (h > 2047) h = 2047;
        if (v > 2047) v = 2047;
        pix(h, v, 12'($urandom_range(0, 4095)));
      end
    end
    rom_mode = 0;
  endtask

  initial begin
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
    test_reset();
    test_passthrough();
    test_placement();
    test_transparency();
    test_frame_latch();
    test_edge_clip();
    test_simultaneous();
    test_reset_midframe();
    test_back_to_back();
    pix(5, 5, 12'h000);
    pix(6, 5, 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
